host_cmd_ctrl: RTL and testbench

- Byte-level command parser between the UART receive/transmit pair and a core's 32-bit register bus (cs/we/address/write_data/read_data).
- Decodes framed read/write commands arriving from the host and issues exactly one single-cycle bus access per valid frame.
- Serialises a framed response back to the host.
- Lets the host read and write any core register over a serial link.

---
 rtl/host_cmd_ctrl_if.sv | 26 ++
 rtl/host_cmd_ctrl.sv | 154 +++++++++++++++
 tb/tb_host_cmd_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/host_cmd_ctrl_if.sv
// Host command port bundle: UART rx/tx byte handshakes plus the core register bus.
// master = command controller, slave = UART pair and core side.
interface host_cmd_ctrl_if;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        error;

  modport master (
    input  rx_valid, rx_data, tx_ready, read_data, error,
    output rx_ready, tx_valid, tx_data, cs, we, address, write_data
  );

  modport slave (
    output rx_valid, rx_data, tx_ready, read_data, error,
    input  rx_ready, tx_valid, tx_data, cs, we, address, write_data
  );
endinterface

// File: rtl/host_cmd_ctrl.sv
// Serial host command parser: decodes framed read/write commands into single-cycle
// core register accesses and serialises a framed response back to the host.
module host_cmd_ctrl #(
  parameter logic [7:0] SOC       = 8'h55,
  parameter logic [7:0] EOC       = 8'haa,
  parameter logic [7:0] SOR       = 8'haa,
  parameter logic [7:0] EOR       = 8'h55,
  parameter logic [7:0] RD_CMD    = 8'h10,
  parameter logic [7:0] WR_CMD    = 8'h11,
  parameter logic [7:0] RD_OK     = 8'h7f,
  parameter logic [7:0] WR_OK     = 8'h7e,
  parameter logic [7:0] UNKNOWN   = 8'hfe,
  parameter logic [7:0] FRAME_ERR = 8'hfd,
  parameter logic [7:0] CORE_ERR  = 8'hfc
) (
  input  logic clk,
  input  logic reset_n,
  host_cmd_ctrl_if.master hif
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, EOC_CHK, EXEC, RESP} state_t;

  state_t      state_q;
  logic [7:0]  cmd_q;
  logic [7:0]  addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  cnt_q;
  logic [7:0]  code_q;   // response code byte
  logic [7:0]  arg_q;    // third response byte: address or offending command
  logic [31:0] rdat_q;
  logic        long_q;   // 8-byte read-OK response
  logic        rx_ready_q;
  logic        tx_valid_q;
  logic [7:0]  tx_data_q;
  logic        cs_q;
  logic        we_q;

  logic        rx_fire;
  logic        tx_fire;
  logic [2:0]  nidx;
  logic [2:0]  last_idx;
  logic [7:0]  nxt_byte_d;

  assign rx_fire  = hif.rx_valid & rx_ready_q;
  assign tx_fire  = tx_valid_q & hif.tx_ready;
  assign nidx     = cnt_q + 3'd1;
  assign last_idx = long_q ? 3'd7 : 3'd3;

  // Byte that follows the one currently on tx_data.
  always_comb begin
    nxt_byte_d = EOR;
    case (nidx)
      3'd1: nxt_byte_d = code_q;
      3'd2: nxt_byte_d = arg_q;
      3'd3: nxt_byte_d = long_q ? rdat_q[31:24] : EOR;
      3'd4: nxt_byte_d = rdat_q[23:16];
      3'd5: nxt_byte_d = rdat_q[15:8];
      3'd6: nxt_byte_d = rdat_q[7:0];
      default: nxt_byte_d = EOR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      code_q     <= '0;
      arg_q      <= '0;
      rdat_q     <= '0;
      long_q     <= 1'b0;
      rx_ready_q <= 1'b1;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (rx_fire && hif.rx_data == SOC) state_q <= CMD;
        CMD: if (rx_fire) begin
          cmd_q   <= hif.rx_data;
          state_q <= ADDR;
        end
        ADDR: if (rx_fire) begin
          addr_q  <= hif.rx_data;
          cnt_q   <= '0;
          state_q <= (cmd_q == WR_CMD) ? DATA : EOC_CHK;
        end
        DATA: if (rx_fire) begin
          wdata_q <= {wdata_q[23:0], hif.rx_data};
          cnt_q   <= {1'b0, cnt_q[1:0] + 2'd1};
          if (cnt_q[1:0] == 2'd3) state_q <= EOC_CHK;
        end
        EOC_CHK: if (rx_fire) begin
          rx_ready_q <= 1'b0;
          cnt_q      <= '0;
          long_q     <= 1'b0;
          arg_q      <= cmd_q;
          if (hif.rx_data == EOC && (cmd_q == RD_CMD || cmd_q == WR_CMD)) begin
            state_q <= EXEC;
            cs_q    <= 1'b1;
            we_q    <= (cmd_q == WR_CMD);
          end else begin
            state_q    <= RESP;
            code_q     <= (hif.rx_data != EOC) ? FRAME_ERR : UNKNOWN;
            tx_valid_q <= 1'b1;
            tx_data_q  <= SOR;
          end
        end
        EXEC: begin
          // read_data/error are only valid while cs is high
          cs_q       <= 1'b0;
          we_q       <= 1'b0;
          state_q    <= RESP;
          tx_valid_q <= 1'b1;
          tx_data_q  <= SOR;
          arg_q      <= addr_q;
          rdat_q     <= hif.read_data;
          if (hif.error) begin
            code_q <= CORE_ERR;
          end else if (cmd_q == WR_CMD) begin
            code_q <= WR_OK;
          end else begin
            code_q <= RD_OK;
            long_q <= 1'b1;
          end
        end
        RESP: if (tx_fire) begin
          if (cnt_q == last_idx) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b1;
            cnt_q      <= '0;
          end else begin
            cnt_q     <= nidx;
            tx_data_q <= nxt_byte_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hif.rx_ready   = rx_ready_q;
  assign hif.tx_valid   = tx_valid_q;
  assign hif.tx_data    = tx_data_q;
  assign hif.cs         = cs_q;
  assign hif.we         = we_q;
  assign hif.address    = addr_q;
  assign hif.write_data = wdata_q;

endmodule

// File: tb/tb_host_cmd_ctrl.sv
// Scoreboard bench for host_cmd_ctrl: directed frames push expected tx bytes and bus
// accesses into queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_host_cmd_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic err_on = 1'b0;

  host_cmd_ctrl_if hif();

  host_cmd_ctrl dut (.clk(clk), .reset_n(reset_n), .hif(hif));

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  a;
    logic [31:0] d;
  } bus_t;

  logic [7:0] exp_tx[$];
  bus_t       exp_bus[$];
  int errors = 0;
  int checks = 0;
  int cs_seen = 0;

  // Core model: fixed read contents, error on demand.
  function automatic logic [31:0] core_rd(input logic [7:0] a);
    case (a)
      8'h00: return 32'h63747431;
      8'h01: return 32'h01020304;
      default: return 32'h0;
    endcase
  endfunction
  assign hif.read_data = core_rd(hif.address);
  assign hif.error     = err_on;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic ex_tx(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) exp_tx.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic ex_bus(input logic we, input logic [7:0] a, input logic [31:0] d);
    bus_t b;
    b.we = we; b.a = a; b.d = d;
    exp_bus.push_back(b);
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    hif.rx_valid = 1'b1;
    hif.rx_data  = b;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (hif.rx_ready) break;
    end
    if (n == 200) begin
      errors++;
      $display("FAIL rx_timeout: byte %0h not accepted", b);
    end
    @(posedge clk); #1;
    hif.rx_valid = 1'b0;
  endtask

  task automatic frame(input logic [63:0] v, input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = v[8*(n-1-i) +: 8];
      send(b);
    end
  endtask

  task automatic drain(input string name, input int exp_cs);
    int n;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && !hif.tx_valid) break;
    end
    if (n == 500) begin
      errors++;
      $display("FAIL %s_drain: %0d tx bytes still pending", name, exp_tx.size());
    end
    repeat (3) @(negedge clk);
    chk({name, "_cs_count"}, cs_seen, exp_cs);
    chk({name, "_bus_left"}, exp_bus.size(), 0);
    @(posedge clk); #1;
    cs_seen = 0;
  endtask

  // Monitor: scoreboard pops plus hold/latency/rx-stall protocol checks.
  initial begin
    logic       stall_q = 1'b0;
    logic [7:0] stall_d = '0;
    logic       cs_prev = 1'b0;
    logic [7:0] e;
    bus_t       b;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall_q = 1'b0;
        cs_prev = 1'b0;
      end else begin
        if (hif.tx_valid) chk("rx_ready_in_resp", hif.rx_ready, 0);
        if (stall_q) begin
          chk("tx_valid_hold", hif.tx_valid, 1);
          chk("tx_data_hold", hif.tx_data, stall_d);
        end
        if (cs_prev) chk("sor_latency", {hif.tx_valid, hif.tx_data}, {1'b1, 8'haa});
        if (hif.tx_valid && hif.tx_ready) begin
          if (exp_tx.size() == 0) chk("tx_unexpected", hif.tx_data, 32'hffff_ffff);
          else begin
            e = exp_tx.pop_front();
            chk("tx_byte", hif.tx_data, e);
          end
        end
        if (hif.cs) begin
          cs_seen++;
          if (exp_bus.size() == 0) chk("cs_unexpected", hif.address, 32'hffff_ffff);
          else begin
            b = exp_bus.pop_front();
            chk("bus_we", hif.we, b.we);
            chk("bus_addr", hif.address, b.a);
            if (b.we) chk("bus_wdata", hif.write_data, b.d);
          end
        end
        stall_q = hif.tx_valid && !hif.tx_ready;
        stall_d = hif.tx_data;
        cs_prev = hif.cs;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hif.rx_valid = 1'b0;
    hif.rx_data  = '0;
    hif.tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_rx_ready", hif.rx_ready, 1);
    chk("rst_tx_valid", hif.tx_valid, 0);
    chk("rst_tx_data", hif.tx_data, 0);
    chk("rst_cs_we", {hif.cs, hif.we}, 0);
    chk("rst_address", hif.address, 0);
    chk("rst_write_data", hif.write_data, 0);
    @(posedge clk); #1;

    // write DEADBEEF to 02; cs one cycle after EOC is accepted
    ex_bus(1'b1, 8'h02, 32'hdeadbeef);
    ex_tx(64'haa7e0255, 4);
    frame(64'h551102deadbeefaa, 8);
    @(negedge clk);
    chk("cs_latency", hif.cs, 1);
    drain("write", 1);

    // read 00
    ex_bus(1'b0, 8'h00, 32'h0);
    ex_tx(64'haa7f006374743155, 8);
    frame(64'h551000aa, 4);
    drain("read", 1);

    // garbage then read 01
    ex_bus(1'b0, 8'h01, 32'h0);
    ex_tx(64'haa7f000102030455 | 64'h0000010000000000, 8);
    frame(64'h0013aa, 3);
    frame(64'h551001aa, 4);
    drain("garbage", 1);

    // unknown command, then bad EOC
    ex_tx(64'haafe3355, 4);
    frame(64'h553305aa, 4);
    drain("unknown", 0);
    ex_tx(64'haafd1055, 4);
    frame(64'h55100500, 4);
    drain("frame_err", 0);

    // back-pressure on read response with a pending 55 on rx
    ex_bus(1'b0, 8'h00, 32'h0);
    ex_tx(64'haa7f006374743155, 8);
    ex_bus(1'b0, 8'h01, 32'h0);
    ex_tx(64'haa7f010102030455, 8);
    frame(64'h551000aa, 4);
    hif.tx_ready = 1'b0;
    fork
      send(8'h55);
      begin
        repeat (10) @(posedge clk);
        #1 hif.tx_ready = 1'b1;
      end
    join
    chk("stall_resp_left", exp_tx.size(), 8);
    frame(64'h1001aa, 3);
    drain("backpressure", 2);

    // reset in the middle of a write, then a normal read
    frame(64'h551103112233, 6);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_tx_valid", hif.tx_valid, 0);
    chk("midrst_cs", hif.cs, 0);
    chk("midrst_rx_ready", hif.rx_ready, 1);
    @(posedge clk); #1;
    ex_bus(1'b0, 8'h00, 32'h0);
    ex_tx(64'haa7f006374743155, 8);
    frame(64'h551000aa, 4);
    drain("after_reset", 1);

    // core error on a write to 07
    err_on = 1'b1;
    ex_bus(1'b1, 8'h07, 32'h0);
    ex_tx(64'haafc0755, 4);
    frame(64'h55110700000000aa, 8);
    drain("core_err", 1);
    err_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
